win_scanner: RTL and testbench

Sequential win/draw detector for the tic-tac-toe chip. It sits directly downstream of the board state registers and upstream of the input controller. It consumes the 18-bit board vector and produces the 2-bit `win` status that the input controller uses for game-over error checking. It scans the eight winning lines one per clock on a stable snapshot, and latches the final result until reset.

---
 rtl/win_scanner.sv | 125 ++++++++++++
 tb/tb_win_scanner.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/win_scanner.sv
// Sequential tic-tac-toe win/draw detector: snapshots the board, scans the eight
// lines one per clock, and latches the first result until reset.
module win_scanner (
   input  logic        clk,
   input  logic        reset,
   input  logic [17:0] registers,
   output logic [1:0]  win,
   output logic [2:0]  win_line,
   output logic        busy,
   output logic        game_over
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t      state_q, state_d;
   logic [17:0] snap_q, snap_d;
   logic [2:0]  idx_q, idx_d;
   logic [1:0]  win_q, win_d;
   logic [2:0]  win_line_q, win_line_d;
   logic        game_over_q, game_over_d;

   logic [3:0]  c0, c1, c2;
   logic [1:0]  v0, v1, v2;
   logic        full;

   function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] k);
      return b[{k, 1'b0} +: 2];
   endfunction

   always_comb begin
      c0 = 4'd0;
      c1 = 4'd1;
      c2 = 4'd2;
      case (idx_q)
         3'd0: begin c0 = 4'd0; c1 = 4'd1; c2 = 4'd2; end
         3'd1: begin c0 = 4'd3; c1 = 4'd4; c2 = 4'd5; end
         3'd2: begin c0 = 4'd6; c1 = 4'd7; c2 = 4'd8; end
         3'd3: begin c0 = 4'd0; c1 = 4'd3; c2 = 4'd6; end
         3'd4: begin c0 = 4'd1; c1 = 4'd4; c2 = 4'd7; end
         3'd5: begin c0 = 4'd2; c1 = 4'd5; c2 = 4'd8; end
         3'd6: begin c0 = 4'd0; c1 = 4'd4; c2 = 4'd8; end
         3'd7: begin c0 = 4'd2; c1 = 4'd4; c2 = 4'd6; end
         default: ;
      endcase
      v0 = cell_at(snap_q, c0);
      v1 = cell_at(snap_q, c1);
      v2 = cell_at(snap_q, c2);
   end

   // Illegal (11) cells count as occupied for the draw test.
   always_comb begin
      full = 1'b1;
      for (int unsigned i = 0; i < 9; i++) begin
         if (snap_q[2*i +: 2] == 2'b00) full = 1'b0;
      end
   end

   always_comb begin
      state_d     = state_q;
      snap_d      = snap_q;
      idx_d       = idx_q;
      win_d       = win_q;
      win_line_d  = win_line_q;
      game_over_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (registers != snap_q) begin
               snap_d  = registers;
               idx_d   = '0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (v0 == 2'b01 && v1 == 2'b01 && v2 == 2'b01) begin
               win_d       = 2'b01;
               win_line_d  = idx_q;
               state_d     = DONE;
               game_over_d = 1'b1;
            end else if (v0 == 2'b10 && v1 == 2'b10 && v2 == 2'b10) begin
               win_d       = 2'b10;
               win_line_d  = idx_q;
               state_d     = DONE;
               game_over_d = 1'b1;
            end else if (idx_q == 3'd7) begin
               if (full) begin
                  win_d       = 2'b11;
                  win_line_d  = '0;
                  state_d     = DONE;
                  game_over_d = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end
         DONE: ;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         snap_q      <= '0;
         idx_q       <= '0;
         win_q       <= '0;
         win_line_q  <= '0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         snap_q      <= snap_d;
         idx_q       <= idx_d;
         win_q       <= win_d;
         win_line_q  <= win_line_d;
         game_over_q <= game_over_d;
      end
   end

   assign win       = win_q;
   assign win_line  = win_line_q;
   assign busy      = (state_q == SCAN);
   assign game_over = game_over_q;

endmodule

// File: tb/tb_win_scanner.sv
// Self-checking bench for win_scanner: directed scenarios plus random boards
// compared against a line-by-line reference model of the game rules.
module tb_win_scanner;

   logic        clk;
   logic        reset;
   logic [17:0] registers;
   logic [1:0]  win;
   logic [2:0]  win_line;
   logic        busy;
   logic        game_over;

   int vectors;
   int miscompares;

   win_scanner dut (
      .clk       (clk),
      .reset     (reset),
      .registers (registers),
      .win       (win),
      .win_line  (win_line),
      .busy      (busy),
      .game_over (game_over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Rows, columns and diagonals from board arithmetic.
   function automatic int lcell(input int l, input int j);
      if (l < 3)       return 3*l + j;
      else if (l < 6)  return (l - 3) + 3*j;
      else if (l == 6) return 4*j;
      else             return 2 + 2*j;
   endfunction

   function automatic logic [1:0] cval(input logic [17:0] b, input int c);
      logic [17:0] t;
      t = b >> (2*c);
      return t[1:0];
   endfunction

   // Returns the index of the last line evaluated; w/ln give the latched result.
   function automatic int ref_scan(input logic [17:0] b, output logic [1:0] w, output logic [2:0] ln);
      int nx, no, occ;
      w  = 2'b00;
      ln = 3'd0;
      for (int l = 0; l < 8; l++) begin
         nx = 0;
         no = 0;
         for (int j = 0; j < 3; j++) begin
            if (cval(b, lcell(l, j)) == 2'b01) nx++;
            else if (cval(b, lcell(l, j)) == 2'b10) no++;
         end
         if (nx == 3) begin w = 2'b01; ln = 3'(l); return l; end
         if (no == 3) begin w = 2'b10; ln = 3'(l); return l; end
      end
      occ = 0;
      for (int c = 0; c < 9; c++) if (cval(b, c) != 2'b00) occ++;
      if (occ == 9) w = 2'b11;
      return 7;
   endfunction

   function automatic logic [17:0] rand_board();
      logic [17:0] b;
      int r;
      b = '0;
      for (int c = 0; c < 9; c++) begin
         r = $urandom_range(0, 9);
         if (r >= 9)      b = b | (18'h3 << (2*c));
         else if (r >= 6) b = b | (18'h2 << (2*c));
         else if (r >= 3) b = b | (18'h1 << (2*c));
      end
      return b;
   endfunction

   // Entered at +1 after an edge with registers already differing from the snapshot.
   task automatic check_scan(input logic [17:0] b, input int mid, input logic [17:0] nb,
                             output logic [1:0] wres);
      logic [1:0] w;
      logic [2:0] ln;
      int k;
      k = ref_scan(b, w, ln);
      for (int i = 0; i <= k; i++) begin
         @(posedge clk); #1;
         chk("scan_busy", 32'(busy), 32'd1);
         chk("scan_win", 32'(win), 32'd0);
         chk("scan_go", 32'(game_over), 32'd0);
         if (i == mid) registers = nb;
      end
      @(posedge clk); #1;
      chk("res_win", 32'(win), 32'(w));
      chk("res_line", 32'(win_line), 32'(ln));
      chk("res_go", 32'(game_over), (w != 2'b00) ? 32'd1 : 32'd0);
      chk("res_busy", 32'(busy), 32'd0);
      if (w != 2'b00) begin
         @(posedge clk); #1;
         chk("go_drop", 32'(game_over), 32'd0);
         chk("hold_win", 32'(win), 32'(w));
      end
      wres = w;
   endtask

   task automatic check_hold(input logic [17:0] nb, input logic [1:0] w, input logic [2:0] ln);
      registers = nb;
      repeat (4) begin
         @(posedge clk); #1;
         chk("hold_win", 32'(win), 32'(w));
         chk("hold_line", 32'(win_line), 32'(ln));
         chk("hold_busy", 32'(busy), 32'd0);
         chk("hold_go", 32'(game_over), 32'd0);
      end
   endtask

   task automatic areset();
      #3;
      reset = 1'b0;
      #1;
      chk("ar_win", 32'(win), 32'd0);
      chk("ar_line", 32'(win_line), 32'd0);
      chk("ar_busy", 32'(busy), 32'd0);
      chk("ar_go", 32'(game_over), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   initial begin
      logic [1:0]  w;
      logic [17:0] b, prev;
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      registers   = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_win", 32'(win), 32'd0);
      chk("rst_line", 32'(win_line), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_go", 32'(game_over), 32'd0);
      reset = 1'b1;
      repeat (20) begin
         @(posedge clk); #1;
         chk("idle_busy", 32'(busy), 32'd0);
      end

      registers = 18'h00015;
      check_scan(18'h00015, -1, '0, w);
      check_hold(18'h0002A, 2'b01, 3'd0);

      areset();
      registers = 18'h02225;
      check_scan(18'h02225, -1, '0, w);

      areset();
      registers = 18'h16A59;
      check_scan(18'h16A59, -1, '0, w);

      // A change during the scan must not affect it; the new board is scanned next.
      areset();
      registers = 18'h00129;
      check_scan(18'h00129, 2, 18'h10129, w);
      check_scan(18'h10129, -1, '0, w);

      areset();
      registers = 18'h02225;
      @(posedge clk); #1;
      repeat (2) begin
         @(posedge clk); #1;
      end
      chk("mid_busy", 32'(busy), 32'd1);
      areset();
      check_scan(18'h02225, -1, '0, w);
      areset();
      check_scan(18'h02225, -1, '0, w);

      for (int t = 0; t < 40; t++) begin
         areset();
         prev = '0;
         for (int j = 0; j < 4; j++) begin
            b = rand_board();
            while (b == prev) b = rand_board();
            registers = b;
            check_scan(b, -1, '0, w);
            if (w != 2'b00) break;
            @(posedge clk); #1;
            chk("no_rescan", 32'(busy), 32'd0);
            prev = b;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
